instr_pc_issuer: RTL

//  Front-end PC source for the instruction page walker. Drives its PC request interface
//  (valid/ready + PC + epoch) at up to one request per cycle, sequentially or from redirects.

---
 rtl/instr_pc_issuer.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_pc_issuer.sv
// instr_pc_issuer: front-end PC source feeding the instruction page walker.
// Ports: clk, rst_n (async low); start/halt/stall/redirect_vld/redirect_pc
//   from core control; req_valid/req_ready/req_pc/req_epoch to the walker;
//   rsp_done completion pulses; inflight count, running, err_underflow status.
module instr_pc_issuer #(
    parameter int unsigned          PC_W     = 32,
    parameter logic [PC_W-1:0]      RESET_PC = '0,
    parameter int unsigned          PC_INC   = 4,
    parameter int unsigned          MAX_OUT  = 4,
    parameter int unsigned          EPOCH_W  = 2,
    localparam int unsigned         CNT_W    = $clog2(MAX_OUT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt,
    input  logic                stall,
    input  logic                redirect_vld,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [PC_W-1:0]     req_pc,
    output logic [EPOCH_W-1:0]  req_epoch,
    input  logic                rsp_done,
    output logic [CNT_W-1:0]    inflight,
    output logic                running,
    output logic                err_underflow
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         state;
    logic [0:0]         state_nxt;
    logic               fire;
    logic               dec;
    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W-1:0]   inflight_nxt;
    logic               can_issue;
    logic               valid_nxt;
    logic [PC_W-1:0]    pc_nxt;
    logic [EPOCH_W-1:0] epoch_nxt;
    logic [PC_W-1:0]    pc_inc;
    logic [EPOCH_W-1:0] epoch_inc;

    assign fire      = req_valid & req_ready;
    // A completion with nothing outstanding is an error, never a decrement.
    assign dec       = rsp_done & (inflight != '0);
    assign pc_inc    = req_pc + PC_W'(PC_INC);
    assign epoch_inc = req_epoch + EPOCH_W'(1);
    assign running   = (state == ST_RUN);

    // One extra bit so the credit compare sees the true post-update count.
    assign cnt_sum = {1'b0, inflight}
                   + (CNT_W+1)'(fire)
                   - (CNT_W+1)'(dec);
    assign inflight_nxt = cnt_sum[CNT_W-1:0];

    always_comb begin
        state_nxt = state;
        if (halt)
            state_nxt = ST_IDLE;
        else if (start && state == ST_IDLE)
            state_nxt = ST_RUN;
    end

    assign can_issue = (state_nxt == ST_RUN)
                     && !stall
                     && (cnt_sum < (CNT_W+1)'(MAX_OUT));

    always_comb begin
        valid_nxt = req_valid;
        pc_nxt    = req_pc;
        epoch_nxt = req_epoch;
        if (halt) begin
            valid_nxt = 1'b0;
            if (redirect_vld) begin
                pc_nxt    = redirect_pc;
                epoch_nxt = epoch_inc;
            end else if (fire) begin
                pc_nxt = pc_inc;
            end
        end else if (redirect_vld) begin
            // A held, un-fired request is dropped in favour of the target.
            pc_nxt    = redirect_pc;
            epoch_nxt = epoch_inc;
            valid_nxt = can_issue;
        end else if (fire) begin
            pc_nxt    = pc_inc;
            valid_nxt = can_issue;
        end else if (!req_valid) begin
            valid_nxt = can_issue;
        end
        // Otherwise a pending request holds steady, stall or not.
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            req_valid     <= 1'b0;
            req_pc        <= RESET_PC;
            req_epoch     <= '0;
            inflight      <= '0;
            err_underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_valid <= valid_nxt;
            req_pc    <= pc_nxt;
            req_epoch <= epoch_nxt;
            inflight  <= inflight_nxt;
            if (rsp_done && inflight == '0)
                err_underflow <= 1'b1;
        end
    end

endmodule
